// File: rtl/distance_zone_classifier.sv
// -----------------------------------------------------------------------------
// distance_zone_classifier
//
// Sorts each valid distance sample into a proximity zone (0 clear, 1 far,
// 2 mid, 3 near). The committed zone changes only after DEBOUNCE consecutive
// samples agree on it. Moving to a farther zone uses thresholds raised by
// HYST, so a reading just past a boundary does not make the zone chatter.
// INVALID_LIMIT consecutive zero (no echo) samples raise a sensor fault and
// force the zone to clear.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   distance_value  distance sample, 0 = invalid / no echo
//   distance_valid  sample strobe
//   zone            committed zone, registered
//   alarm_active    zone != 0 and no fault, registered
//   zone_changed    one-cycle pulse per committed zone change
//   fault           INVALID_LIMIT consecutive zero samples seen
// -----------------------------------------------------------------------------
module distance_zone_classifier #(
    parameter int WIDTH         = 16,
    parameter int NEAR_TH       = 50,
    parameter int MID_TH        = 100,
    parameter int FAR_TH        = 200,
    parameter int HYST          = 10,
    parameter int DEBOUNCE      = 3,
    parameter int INVALID_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] distance_value,
    input  logic             distance_valid,
    output logic [1:0]       zone,
    output logic             alarm_active,
    output logic             zone_changed,
    output logic             fault
);

    // Thresholds are one bit wider than the sample so that a threshold plus
    // HYST cannot wrap around.
    localparam int W1  = WIDTH + 1;
    localparam int DCW = $clog2(DEBOUNCE + 1);
    localparam int ICW = $clog2(INVALID_LIMIT + 1);

    localparam logic [W1-1:0]  NEAR_T = W1'(NEAR_TH);
    localparam logic [W1-1:0]  MID_T  = W1'(MID_TH);
    localparam logic [W1-1:0]  FAR_T  = W1'(FAR_TH);
    localparam logic [W1-1:0]  NEAR_R = W1'(NEAR_TH) + W1'(HYST);
    localparam logic [W1-1:0]  MID_R  = W1'(MID_TH) + W1'(HYST);
    localparam logic [W1-1:0]  FAR_R  = W1'(FAR_TH) + W1'(HYST);
    localparam logic [DCW-1:0] DEB_N  = DCW'(DEBOUNCE);
    localparam logic [ICW-1:0] INV_N  = ICW'(INVALID_LIMIT);

    function automatic logic [1:0] classify(
        input logic [W1-1:0] d,
        input logic [W1-1:0] t_near,
        input logic [W1-1:0] t_mid,
        input logic [W1-1:0] t_far
    );
        if (d < t_near) return 2'd3;
        if (d < t_mid)  return 2'd2;
        if (d < t_far)  return 2'd1;
        return 2'd0;
    endfunction

    logic [1:0]     zone_q, zone_d;
    logic           alarm_q, alarm_d;
    logic           changed_q, changed_d;
    logic           fault_q, fault_d;
    logic [1:0]     pend_q, pend_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [ICW-1:0] icnt_q, icnt_d;

    logic [W1-1:0]  dist_ext;
    logic [1:0]     raw_cls;
    logic [1:0]     rel_cls;
    logic [1:0]     cand;
    logic [ICW-1:0] icnt_next;
    logic [DCW-1:0] dcnt_next;
    logic [1:0]     pend_next;

    always_comb begin
        zone_d    = zone_q;
        changed_d = 1'b0;
        fault_d   = fault_q;
        pend_d    = pend_q;
        dcnt_d    = dcnt_q;
        icnt_d    = icnt_q;
        icnt_next = icnt_q;
        dcnt_next = dcnt_q;
        pend_next = pend_q;

        dist_ext = {1'b0, distance_value};
        raw_cls  = classify(dist_ext, NEAR_T, MID_T, FAR_T);
        rel_cls  = classify(dist_ext, NEAR_R, MID_R, FAR_R);
        // Higher zone number is closer; only moves away use the release thresholds.
        cand     = (raw_cls >= zone_q) ? raw_cls : rel_cls;

        if (distance_valid) begin
            if (distance_value == '0) begin
                pend_d = 2'd0;
                dcnt_d = '0;
                if (icnt_q != INV_N) begin
                    icnt_next = icnt_q + 1'b1;
                end
                icnt_d = icnt_next;
                if (icnt_next == INV_N) begin
                    fault_d = 1'b1;
                    if (zone_q != 2'd0) begin
                        zone_d    = 2'd0;
                        changed_d = 1'b1;
                    end
                end
            end else begin
                icnt_d  = '0;
                fault_d = 1'b0;
                if (cand == zone_q) begin
                    pend_d = 2'd0;
                    dcnt_d = '0;
                end else begin
                    if (cand == pend_q) begin
                        pend_next = pend_q;
                        dcnt_next = dcnt_q + 1'b1;
                    end else begin
                        pend_next = cand;
                        dcnt_next = DCW'(1);
                    end
                    if (dcnt_next == DEB_N) begin
                        zone_d    = pend_next;
                        changed_d = 1'b1;
                        pend_d    = 2'd0;
                        dcnt_d    = '0;
                    end else begin
                        pend_d = pend_next;
                        dcnt_d = dcnt_next;
                    end
                end
            end
        end

        alarm_d = (zone_d != 2'd0) && !fault_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q    <= 2'd0;
            alarm_q   <= 1'b0;
            changed_q <= 1'b0;
            fault_q   <= 1'b0;
            pend_q    <= 2'd0;
            dcnt_q    <= '0;
            icnt_q    <= '0;
        end else begin
            zone_q    <= zone_d;
            alarm_q   <= alarm_d;
            changed_q <= changed_d;
            fault_q   <= fault_d;
            pend_q    <= pend_d;
            dcnt_q    <= dcnt_d;
            icnt_q    <= icnt_d;
        end
    end

    assign zone         = zone_q;
    assign alarm_active = alarm_q;
    assign zone_changed = changed_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_distance_zone_classifier.sv
module tb_distance_zone_classifier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] distance_value = '0;
    logic        distance_valid = 1'b0;
    logic [1:0]  zone;
    logic        alarm_active;
    logic        zone_changed;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    distance_zone_classifier #(
        .WIDTH(16), .NEAR_TH(50), .MID_TH(100), .FAR_TH(200),
        .HYST(10), .DEBOUNCE(3), .INVALID_LIMIT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .distance_value(distance_value),
        .distance_valid(distance_valid),
        .zone          (zone),
        .alarm_active  (alarm_active),
        .zone_changed  (zone_changed),
        .fault         (fault)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [15:0] d;
        logic [1:0]  z;
        logic        a;
        logic        c;
        logic        f;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input int d,
                                input int z, input logic a, input logic c, input logic f);
        vec_t t;
        t.r = r; t.v = v; t.d = 16'(d); t.z = 2'(z); t.a = a; t.c = c; t.f = f;
        vecs.push_back(t);
    endfunction

    // Apply one cycle of inputs, then compare the registered outputs just after the edge.
    task automatic step(input string name, input logic r, input logic v, input int d,
                        input int z, input logic a, input logic c, input logic f);
        logic [4:0] got, exp;
        @(negedge clk);
        rst            = r;
        distance_valid = v;
        distance_value = 16'(d);
        @(posedge clk);
        #1;
        got = {zone, alarm_active, zone_changed, fault};
        exp = {2'(z), a, c, f};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got zone=%0d alarm=%0b chg=%0b fault=%0b, expected zone=%0d alarm=%0b chg=%0b fault=%0b",
                     name, got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        // rst, valid, dist -> zone, alarm, changed, fault
        add(1, 1, 150, 0, 0, 0, 0);   // reset wins over a valid sample
        add(0, 1, 500, 0, 0, 0, 0);
        add(0, 1, 500, 0, 0, 0, 0);
        add(0, 1, 500, 0, 0, 0, 0);
        add(0, 1, 150, 0, 0, 0, 0);   // clear -> far
        add(0, 1, 150, 0, 0, 0, 0);
        add(0, 1, 150, 1, 1, 1, 0);
        add(0, 0,   0, 1, 1, 0, 0);   // invalid strobe ignored, pulse ends
        add(0, 1,  40, 1, 1, 0, 0);   // far -> near
        add(0, 1,  40, 1, 1, 0, 0);
        add(0, 1,  40, 3, 1, 1, 0);
        add(0, 1, 150, 3, 1, 0, 0);   // near -> far
        add(0, 1, 150, 3, 1, 0, 0);
        add(0, 1, 150, 1, 1, 1, 0);
        add(0, 1, 205, 1, 1, 0, 0);   // inside far release band
        add(0, 1, 205, 1, 1, 0, 0);
        add(0, 1, 205, 1, 1, 0, 0);
        add(0, 1, 210, 1, 1, 0, 0);   // at release threshold
        add(0, 1, 210, 1, 1, 0, 0);
        add(0, 1, 210, 0, 0, 1, 0);
        add(0, 1, 150, 0, 0, 0, 0);   // debounce break with gaps
        add(0, 0, 500, 0, 0, 0, 0);
        add(0, 1, 150, 0, 0, 0, 0);
        add(0, 1, 500, 0, 0, 0, 0);
        add(0, 1, 150, 0, 0, 0, 0);
        add(0, 1, 150, 0, 0, 0, 0);
        add(0, 0, 500, 0, 0, 0, 0);
        add(0, 1, 150, 1, 1, 1, 0);
        add(0, 1,  80, 1, 1, 0, 0);   // far -> mid
        add(0, 1,  80, 1, 1, 0, 0);
        add(0, 1,  80, 2, 1, 1, 0);
        add(0, 1,   0, 2, 1, 0, 0);   // zero run to fault, gap inside
        add(0, 1,   0, 2, 1, 0, 0);
        add(0, 0,   0, 2, 1, 0, 0);
        add(0, 1,   0, 2, 1, 0, 0);
        add(0, 1,   0, 0, 0, 1, 1);
        add(0, 1,   0, 0, 0, 0, 1);   // saturated, no second pulse
        add(0, 1,  80, 0, 0, 0, 0);   // fault clears, debounce restarts
        add(0, 1,  80, 0, 0, 0, 0);
        add(0, 1,  80, 2, 1, 1, 0);
        add(0, 1,  40, 2, 1, 0, 0);   // zero sample aborts debounce
        add(0, 1,  40, 2, 1, 0, 0);
        add(0, 1,   0, 2, 1, 0, 0);
        add(0, 1,  40, 2, 1, 0, 0);
        add(0, 1,  40, 2, 1, 0, 0);
        add(0, 1,  40, 3, 1, 1, 0);
        add(0, 1,   0, 3, 1, 0, 0);   // nonzero sample resets zero count
        add(0, 1,   0, 3, 1, 0, 0);
        add(0, 1,   0, 3, 1, 0, 0);
        add(0, 1,  40, 3, 1, 0, 0);
        add(0, 1,   0, 3, 1, 0, 0);
        add(0, 1,   0, 3, 1, 0, 0);
        add(0, 1,   0, 3, 1, 0, 0);
        add(0, 1,   0, 0, 0, 1, 1);
        add(0, 1,  50, 0, 0, 0, 0);   // exactly NEAR_TH is mid
        add(0, 1,  50, 0, 0, 0, 0);
        add(0, 1,  50, 2, 1, 1, 0);
        add(0, 1,  49, 2, 1, 0, 0);   // just below NEAR_TH is near
        add(0, 1,  49, 2, 1, 0, 0);
        add(0, 1,  49, 3, 1, 1, 0);
        add(0, 1,  59, 3, 1, 0, 0);   // below near release stays near
        add(0, 1,  60, 3, 1, 0, 0);
        add(0, 1,  60, 3, 1, 0, 0);
        add(0, 1,  60, 2, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].r, vecs[i].v, int'(vecs[i].d),
                 int'(vecs[i].z), vecs[i].a, vecs[i].c, vecs[i].f);
        end

        // Reset in the middle of a debounce restarts the count.
        step("mid_rst",    1, 0,   0, 0, 0, 0, 0);
        step("mid_s1",     0, 1, 150, 0, 0, 0, 0);
        step("mid_s2",     0, 1, 150, 0, 0, 0, 0);
        step("mid_rst2",   1, 1, 150, 0, 0, 0, 0);
        step("mid_s3",     0, 1, 150, 0, 0, 0, 0);
        step("mid_s4",     0, 1, 150, 0, 0, 0, 0);
        step("mid_commit", 0, 1, 150, 1, 1, 1, 0);

        // Reset clears an active fault and the zero-sample count.
        step("flt_z1",     0, 1, 0, 1, 1, 0, 0);
        step("flt_z2",     0, 1, 0, 1, 1, 0, 0);
        step("flt_z3",     0, 1, 0, 1, 1, 0, 0);
        step("flt_z4",     0, 1, 0, 0, 0, 1, 1);
        step("flt_rst",    1, 1, 0, 0, 0, 0, 0);
        step("flt_after1", 0, 1, 0, 0, 0, 0, 0);
        step("flt_after2", 0, 1, 0, 0, 0, 0, 0);
        step("flt_after3", 0, 1, 0, 0, 0, 0, 0);
        step("flt_after4", 0, 1, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
